// File: rtl/adat_pkg.sv
// Shared definitions for the ADAT transmit path.
//   ADAT_CHANNELS / ADAT_SAMPLE_W / ADAT_USER_W : frame geometry
//   ADAT_AUDIO_W  : width of one packed 8-channel sample set
//   sched_state_t : frame scheduler FSM states (also exported for debug)
package adat_pkg;

    localparam int ADAT_CHANNELS = 8;
    localparam int ADAT_SAMPLE_W = 24;
    localparam int ADAT_USER_W   = 4;
    localparam int ADAT_AUDIO_W  = ADAT_CHANNELS * ADAT_SAMPLE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_BUSY  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/adat_frame_tick.sv
// Frame-rate pacing from the system clock via a phase accumulator.
//   clk, rst : system clock, asynchronous active-high reset
//   enable   : accumulator runs while high, held at zero while low
//   tick     : one-cycle pulse at SAMPLE_RATE on average (combinational from acc)
// Each cycle acc += SAMPLE_RATE; when the sum reaches CLK_FREQ the excess is
// kept, so the long-run rate is exact (48 kHz @ 50 MHz gives 1041/1042 spacing).
module adat_frame_tick #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned SAMPLE_RATE = 48000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    logic [31:0] acc_q, acc_d;
    logic [32:0] sum;

    always_comb begin
        // 33-bit sum so acc + SAMPLE_RATE cannot wrap before the compare
        sum   = {1'b0, acc_q} + 33'(SAMPLE_RATE);
        acc_d = acc_q;
        tick  = 1'b0;
        if (!enable) begin
            acc_d = '0;
        end else if (sum >= 33'(CLK_FREQ)) begin
            acc_d = 32'(sum - 33'(CLK_FREQ));
            tick  = 1'b1;
        end else begin
            acc_d = sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/adat_tx_scheduler.sv
// Frame scheduler between an audio source and the ADAT frame generator.
//   clk, rst        : system clock, asynchronous active-high reset
//   enable          : schedule frames; low = finish current frame then idle
//   s_valid/s_ready : upstream sample-set handshake. A set transfers on a
//                     cycle where both are high; s_ready is registered
//                     (= holding register empty) and never depends on s_valid.
//   s_data, s_user  : 8 x 24 b sample set (ch0 in MSBs) and user nibble
//   gen_audio/user  : set presented to generator, held from LOAD to next LOAD
//   gen_start       : one-cycle start pulse; gen_frame_done ends the frame
//   busy            : frame in flight
//   underrun        : pulse, a frame was loaded with no sample set held
//   overrun         : pulse, a tick was dropped because one was already pending
//   frame_count     : frames started since reset (wraps)
//   dbg_state       : current FSM state
module adat_tx_scheduler
    import adat_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned SAMPLE_RATE   = 48000,
    parameter int unsigned UNDERRUN_ZERO = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ADAT_AUDIO_W-1:0] s_data,
    input  logic [ADAT_USER_W-1:0]  s_user,
    output logic [ADAT_AUDIO_W-1:0] gen_audio,
    output logic [ADAT_USER_W-1:0]  gen_user,
    output logic                    gen_start,
    input  logic                    gen_frame_done,
    output logic                    busy,
    output logic                    underrun,
    output logic                    overrun,
    output logic [31:0]             frame_count,
    output sched_state_t            dbg_state
);

    sched_state_t            state_q, state_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [ADAT_AUDIO_W-1:0] hold_data_q, hold_data_d;
    logic [ADAT_USER_W-1:0]  hold_user_q, hold_user_d;
    logic [ADAT_AUDIO_W-1:0] gen_audio_q, gen_audio_d;
    logic [ADAT_USER_W-1:0]  gen_user_q, gen_user_d;
    logic                    pending_q, pending_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic                    tick;
    logic                    capture;

    adat_frame_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .SAMPLE_RATE(SAMPLE_RATE)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    assign s_ready     = !hold_valid_q;
    assign capture     = s_valid && !hold_valid_q;
    assign gen_audio   = gen_audio_q;
    assign gen_user    = gen_user_q;
    assign frame_count = frame_count_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d       = state_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        hold_user_d   = hold_user_q;
        gen_audio_d   = gen_audio_q;
        gen_user_d    = gen_user_q;
        pending_d     = pending_q;
        frame_count_d = frame_count_q;
        gen_start     = 1'b0;
        busy          = 1'b0;
        underrun      = 1'b0;
        overrun       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;  // no stale tick survives an idle period
                if (enable) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick || pending_q) state_d = ST_LOAD;
                else if (!enable)      state_d = ST_IDLE;
            end
            ST_LOAD: begin
                pending_d = 1'b0;
                if (hold_valid_q) begin
                    gen_audio_d  = hold_data_q;
                    gen_user_d   = hold_user_q;
                    hold_valid_d = 1'b0;
                end else begin
                    underrun    = 1'b1;
                    gen_audio_d = (UNDERRUN_ZERO != 0) ? '0 : gen_audio_q;
                end
                state_d = ST_START;
            end
            ST_START: begin
                gen_start     = 1'b1;
                frame_count_d = frame_count_q + 32'd1;
                state_d       = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (gen_frame_done) state_d = enable ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A tick outside WAIT is remembered once; a second one is dropped.
        // In LOAD the pending tick has just been consumed, so a new one
        // re-arms pending instead of counting as an overrun.
        if (tick && state_q != ST_WAIT) begin
            if (pending_q && state_q != ST_LOAD) overrun   = 1'b1;
            else                                 pending_d = 1'b1;
        end

        // Capture wins over the LOAD clear: only possible on an underrun
        // LOAD (hold empty), where the new set belongs to the next frame.
        if (capture) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_data;
            hold_user_d  = s_user;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            hold_user_q   <= '0;
            gen_audio_q   <= '0;
            gen_user_q    <= '0;
            pending_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            hold_user_q   <= hold_user_d;
            gen_audio_q   <= gen_audio_d;
            gen_user_q    <= gen_user_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
